pc_sequencer: RTL and testbench

Parametrised program-counter stage for the fetch front end, the next generation of the single-cycle PC adder. It registers the PC and selects the next PC from sequential, PC-relative and register-indirect targets. It also supports stall and a boot cycle, and traps misaligned control-flow targets to a trap vector, holding there until acknowledged. It drives the instruction-memory address and the PC/PC+4 values consumed by decode and the jump writeback path.

---
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with boot cycle, stall, PC-relative/indirect redirect and misaligned-target trap.
// Optional 64-bit retired-instruction counter built when RETIRE_CNT_EN is defined.
module pc_sequencer #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [1:0]            pc_src,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic                  trap_ack,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  fetch_valid_o,
  output logic                  trap_o,
  output logic [DATA_WIDTH-1:0] epc_o,
  output logic [DATA_WIDTH-1:0] badaddr_o,
  output logic [63:0]           retired_count_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] FOUR     = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] CLR_BIT0 = ~DATA_WIDTH'(1);

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   pc_reg, pc_next;
  logic [DATA_WIDTH-1:0]   epc_reg, epc_next;
  logic [DATA_WIDTH-1:0]   badaddr_reg, badaddr_next;
  logic [DATA_WIDTH-1:0]   pc_plus4;
  logic [DATA_WIDTH-1:0]   target_rel;
  logic [DATA_WIDTH-1:0]   target_ind;
  logic [DATA_WIDTH-1:0]   target;
  logic                    misaligned;

  assign pc_plus4   = pc_reg + FOUR;
  assign target_rel = pc_reg + imm;
  assign target_ind = (rs1 + imm) & CLR_BIT0;

  // Sequential targets (including the reserved encoding) are never checked.
  always_comb begin
    target     = pc_plus4;
    misaligned = 1'b0;
    case (pc_src)
      2'b01: begin
        target     = target_rel;
        misaligned = |target_rel[1:0];
      end
      2'b10: begin
        target     = target_ind;
        misaligned = target_ind[1];
      end
      default: begin
        target     = pc_plus4;
        misaligned = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    epc_next     = epc_reg;
    badaddr_next = badaddr_reg;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        if (!stall) begin
          if (misaligned) begin
            pc_next      = TRAP_VECTOR;
            epc_next     = pc_reg;
            badaddr_next = target;
            state_next   = TRAP;
          end else begin
            pc_next = target;
          end
        end
      end
      TRAP: begin
        if (trap_ack) state_next = RUN;
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= BOOT;
      pc_reg      <= RESET_VECTOR;
      epc_reg     <= '0;
      badaddr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      epc_reg     <= epc_next;
      badaddr_reg <= badaddr_next;
    end
  end

`ifdef RETIRE_CNT_EN
  logic [63:0] retired_reg;
  logic        advance;

  assign advance = (state_reg == RUN) && !stall && !misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_reg <= '0;
    end else if (advance) begin
      retired_reg <= retired_reg + 64'd1;
    end
  end

  assign retired_count_o = retired_reg;
`else
  assign retired_count_o = '0;
`endif

  assign pc_o          = pc_reg;
  assign pc_plus4_o    = pc_plus4;
  assign fetch_valid_o = (state_reg == RUN);
  assign trap_o        = (state_reg == TRAP);
  assign epc_o         = epc_reg;
  assign badaddr_o     = badaddr_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer, checked against a behavioural model of the PC rules.
// Expects retired_count_o to count advances when RETIRE_CNT_EN is defined, and to stay 0 otherwise.
module tb_pc_sequencer;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        trap_ack;
  logic [31:0] pc_o, pc_plus4_o, epc_o, badaddr_o;
  logic        fetch_valid_o, trap_o;
  logic [63:0] retired_count_o;

  int vectors = 0;
  int miscompares = 0;

  // Model state: mode 0 = boot, 1 = running, 2 = trapped.
  int          m_mode;
  logic [31:0] m_pc, m_epc, m_bad;
  logic [63:0] m_cnt;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .imm(imm), .rs1(rs1),
    .trap_ack(trap_ack), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .fetch_valid_o(fetch_valid_o), .trap_o(trap_o), .epc_o(epc_o),
    .badaddr_o(badaddr_o), .retired_count_o(retired_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = RV;
    m_epc  = '0;
    m_bad  = '0;
    m_cnt  = '0;
  endtask

  task automatic check_all();
    logic [63:0] exp_cnt;
`ifdef RETIRE_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 64'd0;
`endif
    check("pc", {32'd0, pc_o}, {32'd0, m_pc});
    check("pc_plus4", {32'd0, pc_plus4_o}, {32'd0, m_pc + 32'd4});
    check("fetch_valid", {63'd0, fetch_valid_o}, {63'd0, (m_mode == 1)});
    check("trap", {63'd0, trap_o}, {63'd0, (m_mode == 2)});
    check("epc", {32'd0, epc_o}, {32'd0, m_epc});
    check("badaddr", {32'd0, badaddr_o}, {32'd0, m_bad});
    check("retired", retired_count_o, exp_cnt);
  endtask

  // Apply one cycle of inputs, check current outputs, advance model across the edge.
  task automatic step(input logic st, input logic [1:0] src, input logic [31:0] im,
                      input logic [31:0] r, input logic ack);
    logic [31:0] t;
    logic        mis;
    stall = st; pc_src = src; imm = im; rs1 = r; trap_ack = ack;
    #1;
    check_all();
    $display("step mode=%0d pc=%h stall=%b src=%0d imm=%h rs1=%h ack=%b", m_mode, m_pc, st, src, im, r, ack);
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (!st) begin
        if (src == 2'd1) begin
          t = m_pc + im;
          mis = (t % 4) != 0;
        end else if (src == 2'd2) begin
          t = (r + im) & 32'hFFFF_FFFE;
          mis = (t % 4) != 0;
        end else begin
          t = m_pc + 32'd4;
          mis = 1'b0;
        end
        if (mis) begin
          m_epc = m_pc; m_bad = t; m_pc = TV; m_mode = 2;
        end else begin
          m_pc = t; m_cnt = m_cnt + 64'd1;
        end
      end
    end else begin
      if (ack) m_mode = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pc_src = 2'd0; imm = '0; rs1 = '0; trap_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    #1;

    // Boot then sequential fetch 0,4,8,C -> 0x10
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    check("seq_to_0x10", {32'd0, pc_o}, 64'h10);
    step(1'b0, 2'd1, 32'hFFFF_FFF8, 32'd0, 1'b0);
    check("branch_back", {32'd0, pc_o}, 64'h08);
    step(1'b0, 2'd2, 32'h20, 32'h101, 1'b0);
    check("jalr_clr_bit0", {32'd0, pc_o}, 64'h120);
    check("jalr_no_trap", {63'd0, trap_o}, 64'd0);
    step(1'b0, 2'd2, 32'd0, 32'h40, 1'b0);
    step(1'b0, 2'd1, 32'd6, 32'd0, 1'b0);
    check("trap_raised", {63'd0, trap_o}, 64'd1);
    check("trap_pc", {32'd0, pc_o}, {32'd0, TV});
    check("trap_epc", {32'd0, epc_o}, 64'h40);
    check("trap_bad", {32'd0, badaddr_o}, 64'h46);
    step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 2'd1, 32'd8, 32'd0, 1'b0);
    step(1'b0, 2'd2, 32'd0, 32'h200, 1'b0);
    check("trap_hold", {32'd0, pc_o}, {32'd0, TV});
    step(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    check("resume_valid", {63'd0, fetch_valid_o}, 64'd1);
    step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    check("resume_next", {32'd0, pc_o}, 64'h104);
    // Stray ack and reserved encoding in RUN
    step(1'b0, 2'd3, 32'd12, 32'd0, 1'b1);
    // Stall and wrap
    step(1'b0, 2'd2, 32'd0, 32'hFFFF_FFF8, 1'b0);
    step(1'b1, 2'd1, 32'd3, 32'd0, 1'b0);
    step(1'b1, 2'd2, 32'd0, 32'd2, 1'b0);
    check("stall_hold", {32'd0, pc_o}, 64'hFFFF_FFF8);
    step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    check("wrap_zero", {32'd0, pc_o}, 64'h0);
    // Trap, then asynchronous reset between edges
    step(1'b0, 2'd1, 32'd2, 32'd0, 1'b0);
    check("trap2_raised", {63'd0, trap_o}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    rst = 1'b0;
    #1;
    check_all();

    // Randomized phase
    for (int n = 0; n < 300; n++) begin
      logic        st, ak;
      logic [1:0]  src;
      logic [31:0] im, r;
      st  = ($urandom_range(0, 3) == 0);
      src = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) im = $urandom;
      else im = 32'($urandom_range(0, 128)) - 32'd64;
      r   = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      ak  = 1'($urandom_range(0, 1));
      step(st, src, im, r, ak);
    end
    #1;
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
